// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution sequencer.
// Derived sizes follow valid-mode convolution (no padding).
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 3;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int TAPS  = K * K;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_delay_line.sv
// DEPTH-stage shift register for the sequencer sideband.
// flush clears every stage on the next edge.
module conv_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Shift by one stage, or load zeros on flush.
    always_comb begin
        pipe_d[0] = flush ? '0 : din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = flush ? '0 : pipe_q[i-1];
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM for one valid-mode KxK convolution pass.
// Issues one tap read per cycle and data-aligned MAC/write strobes.
module conv_sequencer #(
    parameter int IMG_W   = conv_pkg::IMG_W,
    parameter int IMG_H   = conv_pkg::IMG_H,
    parameter int K       = conv_pkg::K,
    parameter int ADDR_W  = 10,
    parameter int OADDR_W = 10,
    parameter int MEM_LAT = 1,
    parameter int ACC_LAT = 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     img_rd_en,
    output logic [ADDR_W-1:0]        img_addr,
    output logic [$clog2(K*K)-1:0]   wgt_addr,
    output logic                     mac_clr,
    output logic                     mac_en,
    output logic                     out_we,
    output logic [OADDR_W-1:0]       out_addr
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int WW    = $clog2(K*K);
    localparam int RW    = conv_pkg::cnt_w(OUT_H);
    localparam int CW    = conv_pkg::cnt_w(OUT_W);
    localparam int KW    = conv_pkg::cnt_w(K);
    localparam int DL    = MEM_LAT + ACC_LAT;
    localparam int DW    = conv_pkg::cnt_w(DL);
    localparam int S1W   = 3 + OADDR_W;
    localparam int S2W   = 1 + OADDR_W;

    import conv_pkg::*;

    state_e state_q, state_d;
    logic [RW-1:0] orow_q, orow_d;
    logic [CW-1:0] ocol_q, ocol_d;
    logic [KW-1:0] kr_q, kr_d;
    logic [KW-1:0] kc_q, kc_d;
    logic [DW-1:0] drain_q, drain_d;

    logic               run;
    logic               first_tap;
    logic               last_tap;
    logic               last_win;
    logic [OADDR_W-1:0] oidx;
    logic [S1W-1:0]     s1_in, s1_out;
    logic [S2W-1:0]     s2_in, s2_out;
    logic               m_last;
    logic [OADDR_W-1:0] m_idx;
    logic [OADDR_W-1:0] w_idx;

    assign run       = (state_q == RUN);
    assign first_tap = (kr_q == '0) && (kc_q == '0);
    assign last_tap  = (kr_q == KW'(K-1)) && (kc_q == KW'(K-1));
    assign last_win  = (orow_q == RW'(OUT_H-1)) && (ocol_q == CW'(OUT_W-1));
    assign oidx      = OADDR_W'(32'(orow_q) * OUT_W + 32'(ocol_q));

    // Next state and window/tap counters; abort overrides everything.
    always_comb begin
        state_d = state_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (kc_q == KW'(K-1)) begin
                    kc_d = '0;
                    if (kr_q == KW'(K-1)) begin
                        kr_d = '0;
                        if (ocol_q == CW'(OUT_W-1)) begin
                            ocol_d = '0;
                            if (orow_q == RW'(OUT_H-1)) orow_d = '0;
                            else                        orow_d = orow_q + 1'b1;
                        end else begin
                            ocol_d = ocol_q + 1'b1;
                        end
                    end else begin
                        kr_d = kr_q + 1'b1;
                    end
                end else begin
                    kc_d = kc_q + 1'b1;
                end
                if (last_win && last_tap) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_q == DW'(DL-1)) begin
                    drain_d = '0;
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            orow_d  = '0;
            ocol_d  = '0;
            kr_d    = '0;
            kc_d    = '0;
            drain_d = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            orow_q  <= '0;
            ocol_q  <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            drain_q <= drain_d;
        end
    end

    // Read-side outputs straight from the registered counters.
    always_comb begin
        busy      = (state_q == RUN) || (state_q == DRAIN);
        done      = (state_q == DONE);
        img_rd_en = run;
        img_addr  = '0;
        wgt_addr  = '0;
        if (run) begin
            img_addr = ADDR_W'((32'(orow_q) + 32'(kr_q)) * IMG_W
                               + 32'(ocol_q) + 32'(kc_q));
            wgt_addr = WW'(32'(kr_q) * K + 32'(kc_q));
        end
    end

    assign s1_in = {run, run && first_tap, run && last_tap,
                    run ? oidx : '0};

    conv_delay_line #(
        .DEPTH (MEM_LAT),
        .WIDTH (S1W)
    ) u_mem_dl (
        .clk   (CLK),
        .rst_n (RESET_N),
        .flush (abort),
        .din   (s1_in),
        .dout  (s1_out)
    );

    assign {mac_en, mac_clr, m_last, m_idx} = s1_out;
    assign s2_in = {m_last, m_last ? m_idx : '0};

    conv_delay_line #(
        .DEPTH (ACC_LAT),
        .WIDTH (S2W)
    ) u_acc_dl (
        .clk   (CLK),
        .rst_n (RESET_N),
        .flush (abort),
        .din   (s2_in),
        .dout  (s2_out)
    );

    assign {out_we, w_idx} = s2_out;
    assign out_addr = out_we ? w_idx : '0;

endmodule
